// File: rtl/fft_frame_ctrl.sv
`timescale 1ns/1ps
// fft_frame_ctrl
//   Avalon-ST framing controller for a streaming FFT sink port. It produces
//   sink_valid/sink_sop/sink_eop and the frame-size word for bursts of frames
//   and honours sink_ready backpressure. Frame length, inter-frame gap and
//   frame count are latched from the cfg_* inputs when a burst is accepted.
//
//   Build option: define FFT_FRAME_GAP_EN to build the GAP state and gap
//   counter. Without it, cfg_gap is ignored and frames run back-to-back.
//
//   Ports:
//     clk, reset_n            clock, asynchronous active-low reset
//     start, stop             burst request / end burst after current frame
//     cfg_fftpts              points per frame (power of two, 8..2^LOG2_MAX_PTS)
//     cfg_gap                 idle cycles between frames
//     cfg_nframes             frames per burst, 0 = continuous
//     sink_ready              backpressure from the FFT core
//     sink_valid/sop/eop      Avalon-ST framing strobes
//     sink_error              tied to 2'b00
//     fftpts_out              latched frame size
//     sample_idx              index of the current sample within its frame
//     frame_cnt               frames completed in the current burst
//     busy, done, cfg_err     status: not idle / burst ended / start rejected
module fft_frame_ctrl #(
   parameter int LOG2_MAX_PTS = 11,
   parameter int PTS_W        = LOG2_MAX_PTS + 1,
   parameter int GAP_W        = 8,
   parameter int NF_W         = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    stop,
   input  logic [PTS_W-1:0]        cfg_fftpts,
   input  logic [GAP_W-1:0]        cfg_gap,
   input  logic [NF_W-1:0]         cfg_nframes,
   input  logic                    sink_ready,
   output logic                    sink_valid,
   output logic                    sink_sop,
   output logic                    sink_eop,
   output logic [1:0]              sink_error,
   output logic [PTS_W-1:0]        fftpts_out,
   output logic [LOG2_MAX_PTS-1:0] sample_idx,
   output logic [NF_W-1:0]         frame_cnt,
   output logic                    busy,
   output logic                    done,
   output logic                    cfg_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1
`ifdef FFT_FRAME_GAP_EN
      , S_GAP = 2'd2
`endif
   } state_t;

   state_t                  state_q, state_d;
   logic [NF_W-1:0]         nframes_q;
   logic                    stop_pending;
   logic                    start_ok, xfer, at_eop, eop_xfer, last_frame;
   logic                    valid_d, sop_d, eop_d;
   logic [LOG2_MAX_PTS-1:0] idx_d;
   logic [NF_W-1:0]         fcnt_d;
   logic [PTS_W-1:0]        pts_d;

`ifdef FFT_FRAME_GAP_EN
   logic [GAP_W-1:0]        gap_q;
   logic [GAP_W-1:0]        gap_cnt;
`else
   logic                    unused_cfg_gap;
   assign unused_cfg_gap = ^cfg_gap;
`endif

   // Legal frame sizes: a single bit set, between 8 and 2^LOG2_MAX_PTS.
   function automatic logic pts_legal(input logic [PTS_W-1:0] pts);
      logic [PTS_W-1:0] max_pts;
      max_pts = PTS_W'(1) << LOG2_MAX_PTS;
      return (pts >= PTS_W'(8)) && (pts <= max_pts) &&
             ((pts & (pts - PTS_W'(1))) == '0);
   endfunction

   assign start_ok   = start && pts_legal(cfg_fftpts);
   assign xfer       = (state_q == S_RUN) && sink_ready;
   assign at_eop     = (PTS_W'(sample_idx) == fftpts_out - PTS_W'(1));
   assign eop_xfer   = xfer && at_eop;
   // A stop arriving with the eop transfer still ends the burst at that eop.
   assign last_frame = stop_pending || stop ||
                       ((nframes_q != '0) && (frame_cnt + NF_W'(1) == nframes_q));

   assign busy       = (state_q != S_IDLE);
   assign sink_error = 2'b00;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start_ok) state_d = S_RUN;
         S_RUN: begin
            if (eop_xfer) begin
               if (last_frame) state_d = S_IDLE;
`ifdef FFT_FRAME_GAP_EN
               else if (gap_q != '0) state_d = S_GAP;
`endif
            end
         end
`ifdef FFT_FRAME_GAP_EN
         // The counter is loaded with the gap at eop, so leaving at 1 gives
         // exactly gap idle cycles.
         S_GAP: begin
            if (stop || stop_pending)        state_d = S_IDLE;
            else if (gap_cnt == GAP_W'(1))   state_d = S_RUN;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      idx_d  = sample_idx;
      fcnt_d = frame_cnt;
      pts_d  = fftpts_out;
      if (state_q == S_IDLE) begin
         if (start_ok) begin
            idx_d  = '0;
            fcnt_d = '0;
            pts_d  = cfg_fftpts;
         end
      end else if (xfer) begin
         idx_d = at_eop ? '0 : sample_idx + LOG2_MAX_PTS'(1);
         if (at_eop) fcnt_d = frame_cnt + NF_W'(1);
      end
      valid_d = (state_d == S_RUN);
      sop_d   = valid_d && (idx_d == '0);
      eop_d   = valid_d && (PTS_W'(idx_d) == pts_d - PTS_W'(1));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sink_valid   <= 1'b0;
         sink_sop     <= 1'b0;
         sink_eop     <= 1'b0;
         fftpts_out   <= PTS_W'(8);
         sample_idx   <= '0;
         frame_cnt    <= '0;
         stop_pending <= 1'b0;
         done         <= 1'b0;
         cfg_err      <= 1'b0;
`ifdef FFT_FRAME_GAP_EN
         gap_cnt      <= '0;
`endif
      end else begin
         sink_valid <= valid_d;
         sink_sop   <= sop_d;
         sink_eop   <= eop_d;
         fftpts_out <= pts_d;
         sample_idx <= idx_d;
         frame_cnt  <= fcnt_d;
         done       <= (state_q != S_IDLE) && (state_d == S_IDLE);
         cfg_err    <= (state_q == S_IDLE) && start && !start_ok;
         if (state_d == S_IDLE)
            stop_pending <= 1'b0;
         else if ((state_q != S_IDLE) && stop)
            stop_pending <= 1'b1;
`ifdef FFT_FRAME_GAP_EN
         if (state_q == S_RUN)      gap_cnt <= gap_q;
         else if (state_q == S_GAP) gap_cnt <= gap_cnt - GAP_W'(1);
`endif
      end
   end

   // Burst configuration, captured on an accepted start
   always_ff @(posedge clk) begin
      if ((state_q == S_IDLE) && start_ok) begin
         nframes_q <= cfg_nframes;
`ifdef FFT_FRAME_GAP_EN
         gap_q     <= cfg_gap;
`endif
      end
   end

endmodule
